// File: rtl/pill_pack_ctrl.sv
// Bottle-packing station controller: counts hopper pills against a BCD target,
// sequences bottle swaps and conveyor pauses, and decodes display/beeper controls.
//
// state  | meaning
// -------+-------------------------------------------------
// SET    | operator adjusts target, waits for start
// RUN    | hopper open, counting pills into the bottle
// SWAP   | bottle full, timed swap, pills ignored
// PAUSE  | conveyor stopped, counts frozen
// DONE   | batch complete, waits for acknowledge
module pill_pack_ctrl #(
    parameter int DEFAULT_TARGET = 5,
    parameter int MAX_BOTTLES    = 10,
    parameter int SWAP_CYCLES    = 2000
) (
    input  logic       clk_1khz,
    input  logic       rst_n,
    input  logic       btn_inc,
    input  logic       btn_start,
    input  logic       hopper_in,
    input  logic       conveyor_stop,
    output logic       hopper_en,
    output logic [3:0] disp_1,
    output logic [3:0] disp_2,
    output logic [3:0] disp_3,
    output logic [3:0] disp_4,
    output logic [3:0] disp_5,
    output logic [3:0] disp_6,
    output logic [5:0] flicker_mask,
    output logic [1:0] beep_mode
);

    localparam logic [2:0] ST_SET   = 3'd0;
    localparam logic [2:0] ST_RUN   = 3'd1;
    localparam logic [2:0] ST_SWAP  = 3'd2;
    localparam logic [2:0] ST_PAUSE = 3'd3;
    localparam logic [2:0] ST_DONE  = 3'd4;

    localparam logic [7:0]  TARGET_RST  = {4'(DEFAULT_TARGET / 10), 4'(DEFAULT_TARGET % 10)};
    localparam logic [7:0]  BOTTLES_MAX = {4'(MAX_BOTTLES / 10), 4'(MAX_BOTTLES % 10)};
    localparam logic [10:0] SWAP_LAST   = 11'(SWAP_CYCLES - 1);

    logic [2:0]  state;
    logic [7:0]  target;
    logic [7:0]  pills;
    logic [7:0]  bottles;
    logic [10:0] swap_cnt;

    logic [3:0] sync_a;
    logic [3:0] sync_b;
    logic [3:0] sync_c;
    logic [2:0] ev;
    logic       ev_inc;
    logic       ev_start;
    logic       ev_pill;
    logic       stop;
    logic [7:0] pill_next;
    logic [7:0] target_next;

    function automatic logic [7:0] bcd_inc(input logic [7:0] v);
        if (v[3:0] == 4'd9)
            return {(v[7:4] == 4'd9) ? 4'd0 : v[7:4] + 4'd1, 4'd0};
        else
            return {v[7:4], v[3:0] + 4'd1};
    endfunction

    // Stop gets a third stage so it lines up with the registered edge events;
    // that makes stop win cleanly over a pill sampled on the same edge.
    always_ff @(posedge clk_1khz or negedge rst_n) begin
        if (!rst_n) begin
            sync_a <= '0;
            sync_b <= '0;
            sync_c <= '0;
            ev     <= '0;
        end else begin
            sync_a <= {conveyor_stop, hopper_in, btn_start, btn_inc};
            sync_b <= sync_a;
            sync_c <= sync_b;
            ev     <= sync_b[2:0] & ~sync_c[2:0];
        end
    end

    assign ev_inc      = ev[0];
    assign ev_start    = ev[1];
    assign ev_pill     = ev[2];
    assign stop        = sync_c[3];
    assign pill_next   = bcd_inc(pills);
    assign target_next = (bcd_inc(target) == 8'h00) ? 8'h01 : bcd_inc(target);

    always_ff @(posedge clk_1khz or negedge rst_n) begin
        if (!rst_n) begin
            state    <= ST_SET;
            target   <= TARGET_RST;
            pills    <= '0;
            bottles  <= '0;
            swap_cnt <= '0;
        end else begin
            case (state)
                ST_SET: begin
                    if (ev_inc)
                        target <= target_next;
                    if (ev_start) begin
                        pills <= '0;
                        state <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    if (stop) begin
                        state <= ST_PAUSE;
                    end else if (ev_pill) begin
                        pills <= pill_next;
                        if (pill_next == target) begin
                            bottles  <= bcd_inc(bottles);
                            swap_cnt <= '0;
                            state    <= ST_SWAP;
                        end
                    end
                end
                ST_SWAP: begin
                    if (swap_cnt == SWAP_LAST) begin
                        pills <= '0;
                        state <= (bottles == BOTTLES_MAX) ? ST_DONE : ST_RUN;
                    end else if (!stop) begin
                        swap_cnt <= swap_cnt + 11'd1;
                    end
                end
                ST_PAUSE: begin
                    if (!stop)
                        state <= ST_RUN;
                end
                ST_DONE: begin
                    if (ev_start) begin
                        bottles <= '0;
                        pills   <= '0;
                        state   <= ST_SET;
                    end
                end
                default: state <= ST_SET;
            endcase
        end
    end

    always_comb begin
        hopper_en    = 1'b0;
        flicker_mask = 6'b000000;
        beep_mode    = 2'd0;
        case (state)
            ST_SET:   flicker_mask = 6'b000011;
            ST_RUN:   hopper_en = 1'b1;
            ST_SWAP:  beep_mode = 2'd1;
            ST_PAUSE: begin
                flicker_mask = 6'b111111;
                beep_mode    = 2'd2;
            end
            ST_DONE: begin
                flicker_mask = 6'b110000;
                beep_mode    = 2'd3;
            end
            default: ;
        endcase
    end

    assign disp_1 = target[7:4];
    assign disp_2 = target[3:0];
    assign disp_3 = pills[7:4];
    assign disp_4 = pills[3:0];
    assign disp_5 = bottles[7:4];
    assign disp_6 = bottles[3:0];

endmodule

// File: tb/tb_pill_pack_ctrl.sv
// Bench for pill_pack_ctrl: directed vector table, corner-case sequences and
// randomized traffic checked against an integer-level reference model.
module tb_pill_pack_ctrl;

    localparam int TB_TARGET = 5;
    localparam int TB_MAX    = 2;
    localparam int TB_SWAP   = 20;

    logic       clk_1khz = 1'b0;
    logic       rst_n = 1'b0;
    logic       btn_inc = 1'b0;
    logic       btn_start = 1'b0;
    logic       hopper_in = 1'b0;
    logic       conveyor_stop = 1'b0;
    logic       hopper_en;
    logic [3:0] disp_1, disp_2, disp_3, disp_4, disp_5, disp_6;
    logic [5:0] flicker_mask;
    logic [1:0] beep_mode;

    always #5 clk_1khz = ~clk_1khz;

    pill_pack_ctrl #(
        .DEFAULT_TARGET(TB_TARGET),
        .MAX_BOTTLES(TB_MAX),
        .SWAP_CYCLES(TB_SWAP)
    ) dut (
        .clk_1khz(clk_1khz),
        .rst_n(rst_n),
        .btn_inc(btn_inc),
        .btn_start(btn_start),
        .hopper_in(hopper_in),
        .conveyor_stop(conveyor_stop),
        .hopper_en(hopper_en),
        .disp_1(disp_1),
        .disp_2(disp_2),
        .disp_3(disp_3),
        .disp_4(disp_4),
        .disp_5(disp_5),
        .disp_6(disp_6),
        .flicker_mask(flicker_mask),
        .beep_mode(beep_mode)
    );

    logic [32:0] dut_vec;
    assign dut_vec = {hopper_en, disp_1, disp_2, disp_3, disp_4, disp_5, disp_6,
                      flicker_mask, beep_mode};

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model: plain integers, inputs seen through a sample history.
    typedef enum int {M_SET, M_RUN, M_SWAP, M_PAUSE, M_DONE} mode_t;
    mode_t      m_mode;
    int         m_tgt, m_pills, m_bottles, m_left;
    logic [3:0] m_hist [5];

    function automatic logic [32:0] pack(int tgt, int p, int b, logic [5:0] fm,
                                         logic [1:0] bm, logic hen);
        return {hen, 4'(tgt / 10), 4'(tgt % 10), 4'(p / 10), 4'(p % 10),
                4'(b / 10), 4'(b % 10), fm, bm};
    endfunction

    function automatic void model_reset();
        m_mode    = M_SET;
        m_tgt     = TB_TARGET;
        m_pills   = 0;
        m_bottles = 0;
        m_left    = 0;
        for (int i = 0; i < 5; i++) m_hist[i] = 4'b0;
    endfunction

    // sample bits: {stop, hopper, start, inc}; an edge sampled at n acts at n+3
    function automatic void model_step(logic [3:0] smp);
        logic r_inc, r_start, r_pill, stp;
        for (int i = 4; i > 0; i--) m_hist[i] = m_hist[i-1];
        m_hist[0] = smp;
        r_inc   = m_hist[3][0] & ~m_hist[4][0];
        r_start = m_hist[3][1] & ~m_hist[4][1];
        r_pill  = m_hist[3][2] & ~m_hist[4][2];
        stp     = m_hist[3][3];
        case (m_mode)
            M_SET: begin
                if (r_inc) m_tgt = (m_tgt % 99) + 1;
                if (r_start) begin m_pills = 0; m_mode = M_RUN; end
            end
            M_RUN: begin
                if (stp) m_mode = M_PAUSE;
                else if (r_pill) begin
                    m_pills = (m_pills + 1) % 100;
                    if (m_pills == m_tgt) begin
                        m_bottles = (m_bottles + 1) % 100;
                        m_left    = TB_SWAP;
                        m_mode    = M_SWAP;
                    end
                end
            end
            M_SWAP: begin
                if (m_left == 1) begin
                    m_pills = 0;
                    m_mode  = (m_bottles == TB_MAX) ? M_DONE : M_RUN;
                end else if (!stp) m_left--;
            end
            M_PAUSE: if (!stp) m_mode = M_RUN;
            M_DONE: if (r_start) begin m_bottles = 0; m_pills = 0; m_mode = M_SET; end
            default: ;
        endcase
    endfunction

    function automatic logic [32:0] model_vec();
        case (m_mode)
            M_SET:   return pack(m_tgt, m_pills, m_bottles, 6'h03, 2'd0, 1'b0);
            M_RUN:   return pack(m_tgt, m_pills, m_bottles, 6'h00, 2'd0, 1'b1);
            M_SWAP:  return pack(m_tgt, m_pills, m_bottles, 6'h00, 2'd1, 1'b0);
            M_PAUSE: return pack(m_tgt, m_pills, m_bottles, 6'h3F, 2'd2, 1'b0);
            default: return pack(m_tgt, m_pills, m_bottles, 6'h30, 2'd3, 1'b0);
        endcase
    endfunction

    task automatic check(string name, logic [32:0] exp);
        n_cmp++;
        if (dut_vec !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h required %h (t=%0t)", name, dut_vec, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk_1khz);
        if (rst_n) model_step({conveyor_stop, hopper_in, btn_start, btn_inc});
        else model_reset();
        @(negedge clk_1khz);
    endtask

    task automatic run(int n);
        repeat (n) begin
            tick();
            check("model", model_vec());
        end
    endtask

    task automatic press_inc();
        btn_inc = 1'b1;
        tick();
        btn_inc = 1'b0;
        repeat (4) tick();
    endtask

    typedef struct {
        logic        inc, start, hop, stop;
        int          cyc;
        bit          chk;
        logic [32:0] exp;
    } vec_t;

    vec_t tbl [$];

    function automatic vec_t row(logic i, logic s, logic h, logic p, int c, bit k,
                                 int tgt, int pl, int bt, logic [5:0] fm,
                                 logic [1:0] bm, logic hen);
        vec_t v;
        v.inc = i; v.start = s; v.hop = h; v.stop = p; v.cyc = c; v.chk = k;
        v.exp = pack(tgt, pl, bt, fm, bm, hen);
        return v;
    endfunction

    task automatic apply_table();
        for (int i = 0; i < tbl.size(); i++) begin
            {btn_inc, btn_start, hopper_in, conveyor_stop} =
                {tbl[i].inc, tbl[i].start, tbl[i].hop, tbl[i].stop};
            repeat (tbl[i].cyc) tick();
            if (tbl[i].chk) begin
                check($sformatf("row%0d", i), tbl[i].exp);
                check($sformatf("row%0d_model", i), model_vec());
            end
        end
        {btn_inc, btn_start, hopper_in, conveyor_stop} = 4'b0;
        tbl.delete();
    endtask

    initial begin
        model_reset();
        #12;
        check("reset_initial", pack(5, 0, 0, 6'h03, 2'd0, 1'b0));
        @(negedge clk_1khz);
        rst_n = 1'b1;

        // three inc pulses from reset target 05
        tbl.push_back(row(0,0,0,0, 1,1, 5,0,0, 6'h03,2'd0,1'b0));
        for (int k = 6; k <= 8; k++) begin
            tbl.push_back(row(1,0,0,0, 1,0, 0,0,0, 6'h00,2'd0,1'b0));
            tbl.push_back(row(0,0,0,0, 4,1, k,0,0, 6'h03,2'd0,1'b0));
        end
        apply_table();

        for (int i = 0; i < 200 && m_tgt != 95; i++) press_inc();
        check("target_95", pack(95, 0, 0, 6'h03, 2'd0, 1'b0));
        repeat (5) press_inc();
        check("target_wrap_01", pack(1, 0, 0, 6'h03, 2'd0, 1'b0));

        tbl.push_back(row(1,0,0,0, 1,0, 0,0,0, 6'h00,2'd0,1'b0));
        tbl.push_back(row(0,0,0,0, 4,1, 2,0,0, 6'h03,2'd0,1'b0));
        tbl.push_back(row(1,0,0,0, 1,0, 0,0,0, 6'h00,2'd0,1'b0));
        tbl.push_back(row(0,0,0,0, 4,1, 3,0,0, 6'h03,2'd0,1'b0));
        tbl.push_back(row(0,1,0,0, 1,0, 0,0,0, 6'h00,2'd0,1'b0));
        tbl.push_back(row(0,0,0,0, 4,1, 3,0,0, 6'h00,2'd0,1'b1));
        tbl.push_back(row(0,0,1,0, 1,0, 0,0,0, 6'h00,2'd0,1'b0));
        tbl.push_back(row(0,0,0,0, 4,1, 3,1,0, 6'h00,2'd0,1'b1));
        tbl.push_back(row(0,0,1,0, 1,0, 0,0,0, 6'h00,2'd0,1'b0));
        tbl.push_back(row(0,0,0,0, 4,1, 3,2,0, 6'h00,2'd0,1'b1));
        tbl.push_back(row(0,0,1,0, 1,0, 0,0,0, 6'h00,2'd0,1'b0));
        tbl.push_back(row(0,0,0,0, 4,1, 3,3,1, 6'h00,2'd1,1'b0));
        tbl.push_back(row(0,0,1,0, 1,0, 0,0,0, 6'h00,2'd0,1'b0));
        tbl.push_back(row(0,0,0,0, 4,1, 3,3,1, 6'h00,2'd1,1'b0));
        tbl.push_back(row(0,0,0,0,13,1, 3,3,1, 6'h00,2'd1,1'b0));
        tbl.push_back(row(0,0,0,0, 1,1, 3,0,1, 6'h00,2'd0,1'b1));
        tbl.push_back(row(0,0,1,0, 1,0, 0,0,0, 6'h00,2'd0,1'b0));
        tbl.push_back(row(0,0,0,0, 4,1, 3,1,1, 6'h00,2'd0,1'b1));
        // stop and pill sampled together: stop wins, pill dropped
        tbl.push_back(row(0,0,1,1, 1,0, 0,0,0, 6'h00,2'd0,1'b0));
        tbl.push_back(row(0,0,0,1, 2,1, 3,1,1, 6'h00,2'd0,1'b1));
        tbl.push_back(row(0,0,0,1, 1,1, 3,1,1, 6'h3F,2'd2,1'b0));
        tbl.push_back(row(0,0,0,1, 4,1, 3,1,1, 6'h3F,2'd2,1'b0));
        tbl.push_back(row(0,0,0,0, 3,1, 3,1,1, 6'h3F,2'd2,1'b0));
        tbl.push_back(row(0,0,0,0, 1,1, 3,1,1, 6'h00,2'd0,1'b1));
        tbl.push_back(row(0,0,1,0, 1,0, 0,0,0, 6'h00,2'd0,1'b0));
        tbl.push_back(row(0,0,0,0, 4,1, 3,2,1, 6'h00,2'd0,1'b1));
        tbl.push_back(row(0,0,1,0, 1,0, 0,0,0, 6'h00,2'd0,1'b0));
        tbl.push_back(row(0,0,0,0, 4,1, 3,3,2, 6'h00,2'd1,1'b0));
        tbl.push_back(row(0,0,0,0,19,1, 3,0,2, 6'h30,2'd3,1'b0));
        tbl.push_back(row(0,0,1,0, 1,0, 0,0,0, 6'h00,2'd0,1'b0));
        tbl.push_back(row(0,0,0,0, 4,1, 3,0,2, 6'h30,2'd3,1'b0));
        tbl.push_back(row(1,0,0,0, 1,0, 0,0,0, 6'h00,2'd0,1'b0));
        tbl.push_back(row(0,0,0,0, 4,1, 3,0,2, 6'h30,2'd3,1'b0));
        tbl.push_back(row(0,1,0,0, 1,0, 0,0,0, 6'h00,2'd0,1'b0));
        tbl.push_back(row(0,0,0,0, 4,1, 3,0,0, 6'h03,2'd0,1'b0));
        apply_table();

        // asynchronous reset in the middle of a swap
        btn_start = 1'b1; tick(); btn_start = 1'b0; run(4);
        repeat (3) begin
            hopper_in = 1'b1; tick(); hopper_in = 1'b0; run(4);
        end
        check("in_swap", pack(3, 3, 1, 6'h00, 2'd1, 1'b0));
        run(5);
        #2 rst_n = 1'b0;
        #1 check("async_reset", pack(5, 0, 0, 6'h03, 2'd0, 1'b0));
        model_reset();
        @(negedge clk_1khz);
        run(2);
        rst_n = 1'b1;
        run(3);

        for (int c = 0; c < 1500; c++) begin
            btn_inc   = ($urandom_range(0, 11) == 0);
            btn_start = ($urandom_range(0, 15) == 0);
            hopper_in = ($urandom_range(0, 2) == 0);
            if ($urandom_range(0, 59) == 0) conveyor_stop = ~conveyor_stop;
            run(1);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/pill_pack_ctrl.md
# pill_pack_ctrl

Control stage for the bottle-packing station. It counts pills from the hopper pulse train, compares the count against an operator-set target, sequences bottle swaps and conveyor pauses, and produces the six BCD display digits, the flicker mask and the beep mode. The display/beeper stage downstream consumes these outputs directly: digits feed the six 7-segment outputs, and the flicker mask and beep mode gate `clk_4hz` and `clk_2hz`.

## Interface
- `DEFAULT_TARGET`, 5: pills per bottle after reset, legal 1..99.
- `MAX_BOTTLES`, 10: bottles per batch before DONE, legal 1..99.
- `SWAP_CYCLES`, 2000: clk_1khz cycles spent in SWAP (2 s).
- `clk_1khz`  in  1  sole clock, all state on rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `btn_inc`  in  1  target +1 button, level, already debounced.
- `btn_start`  in  1  start/acknowledge button, level, already debounced.
- `hopper_in`  in  1  hopper pulse train; each rising edge is one pill.
- `conveyor_stop`  in  1  conveyor fault/stop, level.
- `hopper_en`  out  1  hopper gate; 1 only in RUN.
- `disp_1`..`disp_6`  out  4 each  BCD: target tens/ones, pill count tens/ones, bottle count tens/ones.
- `flicker_mask`  out  6  bit i=1 blinks `disp_(i+1)`.
- `beep_mode`  out  2  0 off, 1 continuous, 2 slow (2 Hz), 3 fast (4 Hz).

## Operation
- Inputs: `btn_inc`, `btn_start`, `hopper_in` and `conveyor_stop` each pass through a 2-flop synchronizer. The two buttons and `hopper_in` then get a rising-edge detector that yields a 1-cycle event.
- Registers:
  - `target`, BCD 01..99.
  - `pills`, BCD 00..99.
  - `bottles`, BCD 00..99.
  - `state`.
  - `swap_cnt`, 11 bits.
- BCD increment: the ones digit wraps 9→0 and carries into tens. `target` wraps 99→01.
- States:
  - **SET**
    - `btn_inc` event: `target` +1.
    - `btn_start` event: clear `pills`, go to RUN.
  - **RUN**
    - Pill event: `pills` +1.
    - If the incremented value equals `target`: `bottles` +1, `swap_cnt`←0, go to SWAP.
    - `conveyor_stop`=1: go to PAUSE. This has priority over a pill event in the same cycle; that pill is dropped.
  - **SWAP**
    - `pills` holds the target value and pill events are ignored.
    - `swap_cnt` increments each cycle while `conveyor_stop`=0 and freezes while it is 1.
    - At `swap_cnt`=SWAP_CYCLES-1: clear `pills`.
      - If `bottles`=MAX_BOTTLES: go to DONE.
      - Otherwise: go to RUN.
  - **PAUSE**
    - Pill events ignored.
    - `conveyor_stop`=0: return to RUN with counts unchanged.
  - **DONE**
    - Pill events ignored.
    - `btn_start` event: clear `bottles` and `pills`, go to SET.
- Buttons not listed for a state are ignored in that state.
- Output decode:
  - `hopper_en`: 1 only in RUN.
  - `flicker_mask`: 6'b000011 in SET, 6'b111111 in PAUSE, 6'b110000 in DONE, 0 otherwise.
  - `beep_mode`: 1 in SWAP, 2 in PAUSE, 3 in DONE, 0 otherwise.
- Reset (asynchronous, immediate, valid mid-operation):
  - State values: `state`=SET, `target`=DEFAULT_TARGET, `pills`=0, `bottles`=0, `swap_cnt`=0, synchronizers and edge registers 0.
  - Resulting outputs: `disp_1`/`disp_2`=target digits (0/5 by default), `disp_3`..`disp_6`=0, `hopper_en`=0, `flicker_mask`=6'b000011, `beep_mode`=0.

## Timing
- All outputs are registered or decoded from registered state. No combinational path from any input to any output.
- Event latency: an input rising edge sampled at clock edge k produces its event at edge k+2. The resulting counter or state update is visible at edge k+3.
- SWAP lasts exactly SWAP_CYCLES cycles when `conveyor_stop` stays 0.
- `conveyor_stop` entry to PAUSE: 3 cycles after assertion. Exit from PAUSE: 3 cycles after deassertion.
- An input held high counts once; a new event needs a 0 sample first.
- Pill rate above 1 per 3 cycles is unsupported. Every edge at 1 Hz must be counted.

## Test plan
- Reset, then 3 `btn_inc` pulses → `disp_1`/`disp_2`=0/8, `flicker_mask`=000011, `hopper_en`=0.
- Target 95, 5 `btn_inc` pulses → wraps to 01.
- Target 3, start, 3 hopper edges → `pills` 1,2,3.
  - After the third edge: SWAP, `beep_mode`=1, `bottles`=01, `hopper_en`=0.
  - SWAP_CYCLES later: RUN, `pills`=00.
  - A hopper edge during SWAP is not counted.
- Assert `conveyor_stop` in RUN with a pill edge in the same cycle → PAUSE, pill not counted, `flicker_mask`=111111, `beep_mode`=2.
  - Deassert → RUN with counts intact.
- MAX_BOTTLES=2, target 1, 2 pills → DONE after the second SWAP, `beep_mode`=3.
  - `btn_start` → SET, `bottles`=00.
- Assert `rst_n` low mid-SWAP → all outputs take their reset values immediately, without a clock edge.
